// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//   Read-side traffic agent for FIFO throughput/sizing benches. Drains a FIFO
//   read port with a programmable burst/gap pattern and keeps saturating
//   statistics: completed reads, empty-FIFO stall cycles and the longest run
//   of consecutive stall cycles.
//
//   Optional feature macro: READER_DATA_CHECK_EN
//     defined     -> rdata_i is checked against an incrementing sequence
//                    0,1,2,... (mod 2^DATA_W); a mismatch sets the sticky
//                    data_err_o.
//     not defined -> no checker logic, data_err_o tied low, rdata_i unused.
//
//   Handshake: rd_rdy_i is the FIFO's "not empty" (valid) and re_o is our
//   read strobe (ready). A read completes on every clk_i rising edge where
//   re_o=1. re_o is only ever asserted while rd_rdy_i=1, so this block never
//   underflows the FIFO. Read data appears on rdata_i one cycle after the
//   completing edge.
module fifo_burst_reader #(
  parameter int DATA_W = 1,
  parameter int LEN_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic [LEN_W-1:0]  burst_len_i,
  input  logic [LEN_W-1:0]  gap_len_i,
  input  logic              rd_rdy_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic              re_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  read_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  max_stall_o,
  output logic              data_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   burst_len_q, burst_len_d;
  logic [LEN_W-1:0]   gap_len_q, gap_len_d;
  logic [LEN_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [LEN_W-1:0]   gap_cnt_q, gap_cnt_d;

  logic [CNT_W-1:0]   read_cnt_q, read_cnt_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   max_stall_q, max_stall_d;
  logic [CNT_W-1:0]   run_q, run_d;
  logic [CNT_W-1:0]   run_inc;

  logic               rd_fire;
  logic               stall;
  logic               burst_last;
  logic               gap_last;

  // Read strobe is purely combinational so it drops in the same cycle that
  // enable_i or rd_rdy_i falls, and falls with the async reset of state_q.
  assign re_o       = (state_q == ST_BURST) & enable_i & rd_rdy_i;
  assign rd_fire    = re_o;
  assign stall      = (state_q == ST_BURST) & enable_i & ~rd_rdy_i;
  assign burst_last = (burst_len_q != '0) && ((burst_cnt_q + LEN_W'(1)) == burst_len_q);
  assign gap_last   = ((gap_cnt_q + LEN_W'(1)) == gap_len_q);

  assign busy_o      = (state_q != ST_IDLE);
  assign read_cnt_o  = read_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
  assign max_stall_o = max_stall_q;

  // FSM state and burst/gap bookkeeping registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      burst_len_q <= '0;
      gap_len_q   <= '0;
      burst_cnt_q <= '0;
      gap_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      burst_len_q <= burst_len_d;
      gap_len_q   <= gap_len_d;
      burst_cnt_q <= burst_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  // Next-state logic: IDLE -> BURST -> (GAP ->) BURST ...; enable_i low
  // always returns to IDLE on the next edge.
  always_comb begin
    state_d     = state_q;
    burst_len_d = burst_len_q;
    gap_len_d   = gap_len_q;
    burst_cnt_d = burst_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d     = ST_BURST;
          burst_len_d = burst_len_i;
          gap_len_d   = gap_len_i;
          burst_cnt_d = '0;
          gap_cnt_d   = '0;
        end
      end
      ST_BURST: begin
        if (!enable_i) begin
          state_d     = ST_IDLE;
          burst_cnt_d = '0;
        end else if (rd_fire && (burst_len_q != '0)) begin
          if (burst_last) begin
            // End of burst: with a zero gap we simply start the next burst.
            burst_cnt_d = '0;
            gap_cnt_d   = '0;
            if (gap_len_q != '0) begin
              state_d = ST_GAP;
            end
          end else begin
            burst_cnt_d = burst_cnt_q + LEN_W'(1);
          end
        end
      end
      ST_GAP: begin
        if (!enable_i) begin
          state_d   = ST_IDLE;
          gap_cnt_d = '0;
        end else if (gap_last) begin
          // Lengths are re-sampled at every burst start so a running agent
          // can be reprogrammed between bursts.
          state_d     = ST_BURST;
          burst_len_d = burst_len_i;
          gap_len_d   = gap_len_i;
          burst_cnt_d = '0;
          gap_cnt_d   = '0;
        end else begin
          gap_cnt_d = gap_cnt_q + LEN_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Statistics registers; they clear only on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      read_cnt_q  <= '0;
      stall_cnt_q <= '0;
      max_stall_q <= '0;
      run_q       <= '0;
    end else begin
      read_cnt_q  <= read_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      max_stall_q <= max_stall_d;
      run_q       <= run_d;
    end
  end

  // Saturating statistics update; the current stall run is compared with the
  // maximum using its post-increment value so a run's last cycle is counted.
  always_comb begin
    read_cnt_d  = read_cnt_q;
    stall_cnt_d = stall_cnt_q;
    max_stall_d = max_stall_q;
    run_d       = '0;
    run_inc     = (&run_q) ? run_q : (run_q + CNT_W'(1));
    if (rd_fire && !(&read_cnt_q)) begin
      read_cnt_d = read_cnt_q + CNT_W'(1);
    end
    if (stall) begin
      if (!(&stall_cnt_q)) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      run_d = run_inc;
      if (run_inc > max_stall_q) begin
        max_stall_d = run_inc;
      end
    end
  end

`ifdef READER_DATA_CHECK_EN
  logic [DATA_W-1:0] exp_q, exp_d;
  logic [DATA_W-1:0] cmp_q, cmp_d;
  logic              pend_q, pend_d;
  logic              err_q, err_d;

  // Data checker registers: next expected value, value owed by the previous
  // read, and the sticky error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      exp_q  <= '0;
      cmp_q  <= '0;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      exp_q  <= exp_d;
      cmp_q  <= cmp_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  // Each completed read arms a compare of rdata_i one cycle later.
  always_comb begin
    exp_d  = exp_q;
    cmp_d  = cmp_q;
    pend_d = rd_fire;
    err_d  = err_q;
    if (rd_fire) begin
      cmp_d = exp_q;
      exp_d = exp_q + DATA_W'(1);
    end
    if (pend_q && (rdata_i != cmp_q)) begin
      err_d = 1'b1;
    end
  end

  assign data_err_o = err_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^rdata_i;
  assign data_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb_fifo_burst_reader
//   Directed bench for fifo_burst_reader (DATA_W=1, LEN_W=4, CNT_W=4).
//   The narrow counters make saturation reachable in a few cycles.
//   Data-check expectations follow READER_DATA_CHECK_EN.
module tb_fifo_burst_reader;

  localparam int DATA_W = 1;
  localparam int LEN_W  = 4;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              enable;
  logic [LEN_W-1:0]  burst_len;
  logic [LEN_W-1:0]  gap_len;
  logic              rd_rdy;
  logic [DATA_W-1:0] rdata;
  logic              re;
  logic              busy;
  logic [CNT_W-1:0]  read_cnt;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  max_stall;
  logic              data_err;

  int total;
  int bad;

  fifo_burst_reader #(
    .DATA_W(DATA_W),
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .enable_i   (enable),
    .burst_len_i(burst_len),
    .gap_len_i  (gap_len),
    .rd_rdy_i   (rd_rdy),
    .rdata_i    (rdata),
    .re_o       (re),
    .busy_o     (busy),
    .read_cnt_o (read_cnt),
    .stall_cnt_o(stall_cnt),
    .max_stall_o(max_stall),
    .data_err_o (data_err)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: return 1 unit after the next rising edge; inputs driven here
  // settle well before the following edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    enable    = 1'b0;
    rd_rdy    = 1'b0;
    rdata     = '0;
    burst_len = '0;
    gap_len   = '0;
    rst       = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic exp_err;
    total = 0;
    bad   = 0;
`ifdef READER_DATA_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    // Reset state.
    do_reset();
    #1;
    chk("rst_re", 32'(re), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_read_cnt", 32'(read_cnt), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_max_stall", 32'(max_stall), 32'd0);
    chk("rst_data_err", 32'(data_err), 32'd0);

    // Test 1: burst=4 gap=2, FIFO always ready -> 1111_00 repeating.
    burst_len = 4'd4;
    gap_len   = 4'd2;
    rd_rdy    = 1'b1;
    enable    = 1'b1;
    #1;
    chk("t1_idle_re", 32'(re), 32'd0);
    tick();
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("t1_re_k%0d", k), 32'(re), ((k % 6) < 4) ? 32'd1 : 32'd0);
      tick();
    end
    enable = 1'b0;
    #1;
    chk("t1_re_drop", 32'(re), 32'd0);
    chk("t1_read_cnt", 32'(read_cnt), 32'd14);
    chk("t1_stall_cnt", 32'(stall_cnt), 32'd0);
    tick();
    chk("t1_busy_idle", 32'(busy), 32'd0);

    // Test 2: continuous, FIFO empty in cycles 5-7 and 10.
    do_reset();
    burst_len = 4'd0;
    gap_len   = 4'd0;
    rd_rdy    = 1'b1;
    enable    = 1'b1;
    tick();
    for (int k = 0; k < 15; k++) begin
      rd_rdy = !((k >= 5 && k <= 7) || k == 10);
      #1;
      chk($sformatf("t2_re_k%0d", k), 32'(re), 32'(rd_rdy));
      tick();
    end
    chk("t2_stall_cnt", 32'(stall_cnt), 32'd4);
    chk("t2_max_stall", 32'(max_stall), 32'd3);
    chk("t2_read_cnt", 32'(read_cnt), 32'd11);
    chk("t2_busy", 32'(busy), 32'd1);

    // Test 3: burst=3 gap=0 -> re never drops, busy stays high.
    do_reset();
    burst_len = 4'd3;
    gap_len   = 4'd0;
    rd_rdy    = 1'b1;
    enable    = 1'b1;
    tick();
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("t3_re_k%0d", k), 32'(re), 32'd1);
      chk($sformatf("t3_busy_k%0d", k), 32'(busy), 32'd1);
      tick();
    end
    chk("t3_read_cnt", 32'(read_cnt), 32'd9);

    // Test 4: enable dropped after 2 of 4 reads.
    do_reset();
    burst_len = 4'd4;
    gap_len   = 4'd2;
    rd_rdy    = 1'b1;
    enable    = 1'b1;
    tick();
    chk("t4_re_0", 32'(re), 32'd1);
    tick();
    chk("t4_re_1", 32'(re), 32'd1);
    tick();
    enable = 1'b0;
    #1;
    chk("t4_re_same_cycle", 32'(re), 32'd0);
    chk("t4_busy_same_cycle", 32'(busy), 32'd1);
    tick();
    chk("t4_busy_next", 32'(busy), 32'd0);
    chk("t4_read_cnt", 32'(read_cnt), 32'd2);
    tick();
    tick();
    chk("t4_read_cnt_held", 32'(read_cnt), 32'd2);

    // Test 5: saturation at 15 for reads and stalls, then async reset.
    do_reset();
    burst_len = 4'd0;
    gap_len   = 4'd0;
    rd_rdy    = 1'b1;
    enable    = 1'b1;
    tick();
    for (int k = 0; k < 20; k++) tick();
    chk("t5_read_sat", 32'(read_cnt), 32'd15);
    rd_rdy = 1'b0;
    for (int k = 0; k < 17; k++) tick();
    chk("t5_stall_sat", 32'(stall_cnt), 32'd15);
    chk("t5_max_sat", 32'(max_stall), 32'd15);
    chk("t5_read_held", 32'(read_cnt), 32'd15);
    rd_rdy = 1'b1;
    #1;
    chk("t5_re_before_rst", 32'(re), 32'd1);
    rst = 1'b1;
    #1;
    chk("t5_async_re", 32'(re), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    chk("t5_async_read", 32'(read_cnt), 32'd0);
    chk("t5_async_stall", 32'(stall_cnt), 32'd0);
    chk("t5_async_max", 32'(max_stall), 32'd0);
    tick();
    rst = 1'b0;

    // Test 6: data sequence 0,1,0,1,... then one flipped value.
    do_reset();
    burst_len = 4'd0;
    gap_len   = 4'd0;
    rd_rdy    = 1'b1;
    enable    = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      rdata = (k == 0) ? 1'b0 : 1'(k - 1);
      tick();
    end
    chk("t6_err_clean", 32'(data_err), 32'd0);
    rdata = 1'b1;   // read 4 expects 0
    tick();
    chk("t6_err_set", 32'(data_err), 32'(exp_err));
    rdata = 1'b1;   // read 5 expects 1
    tick();
    rdata = 1'b0;   // read 6 expects 0
    tick();
    chk("t6_err_sticky", 32'(data_err), 32'(exp_err));
    enable = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
